stochastic_alu_core: RTL and testbench

Parametrised stochastic arithmetic engine, successor to the fixed 9-bit adder/multiplier top. It accepts two WIDTH-bit unipolar/bipolar probabilities on a valid/ready bus. It converts them to stochastic bit streams with seeded LFSRs, applies one of four operations, and counts the output stream over 2^LOG_LEN bits. The decoded (WIDTH+1)-bit result is returned on a valid/ready bus. It sits between the pin-level serial/parallel front end and the output mux.

---
 rtl/stochastic_alu_core.sv | 131 +++++++++++++
 tb/tb_stochastic_alu_core.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stochastic_alu_core.sv
// Stochastic arithmetic engine. Two operands become LFSR-driven bit streams,
// one of four gate-level operations combines them, and the ones are counted.
module stochastic_alu_core #(
  parameter int          WIDTH   = 9,
  parameter int          LOG_LEN = 17,
  parameter logic [30:0] SEED_A  = 31'd134995,
  parameter logic [30:0] SEED_B  = 31'd7654321
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             sn_bit
);

  localparam int CW = LOG_LEN + 1;
  localparam logic [CW-1:0] GEN_END = {1'b1, {LOG_LEN{1'b0}}};
  localparam logic [CW-1:0] LAST    = GEN_END + CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [30:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [CW-1:0]    ones_q, ones_d, cnt_q, cnt_d;
  logic             sn_bit_q, sn_bit_d, x_d_q, x_d_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             xa, xb, sel, bit_n;

  always_comb begin
    xa  = lfsr_a_q[WIDTH-1:0] < op_a_q;
    xb  = lfsr_b_q[WIDTH-1:0] < op_b_q;
    sel = lfsr_b_q[30];
    case (mode_q)
      2'b00:   bit_n = ~(xa ^ xb);
      2'b01:   bit_n = xa & xb;
      2'b10:   bit_n = sel ? xb : xa;
      default: bit_n = xa & x_d_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;
    sn_bit_d = sn_bit_q;
    x_d_d    = x_d_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d  = S_RUN;
        mode_d   = mode;
        op_a_d   = op_a;
        op_b_d   = op_b;
        lfsr_a_d = SEED_A;
        lfsr_b_d = SEED_B;
        ones_d   = '0;
        cnt_d    = '0;
        sn_bit_d = 1'b0;
        x_d_d    = 1'b0;
      end
      S_RUN: begin
        // cnt_q counts RUN edges: 0..GEN_END-1 generate, 1..GEN_END accumulate
        // the bit generated on the previous edge, LAST latches the result.
        if (cnt_q == LAST) begin
          result_d = ones_q[LOG_LEN -: WIDTH+1];
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q < GEN_END) begin
            lfsr_a_d = {lfsr_a_q[29:0], lfsr_a_q[30] ^ lfsr_a_q[27]};
            lfsr_b_d = {lfsr_b_q[29:0], lfsr_b_q[30] ^ lfsr_b_q[27]};
            sn_bit_d = bit_n;
            x_d_d    = xa;
          end
          if (cnt_q != '0) ones_d = ones_q + CW'(sn_bit_q);
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      op_a_q   <= '0;
      op_b_q   <= '0;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      ones_q   <= '0;
      cnt_q    <= '0;
      sn_bit_q <= 1'b0;
      x_d_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      ones_q   <= ones_d;
      cnt_q    <= cnt_d;
      sn_bit_q <= sn_bit_d;
      x_d_q    <= x_d_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign result    = result_q;
  assign sn_bit    = sn_bit_q;

endmodule

// File: tb/tb_stochastic_alu_core.sv
// Directed bench for stochastic_alu_core at WIDTH=9, LOG_LEN=10.
module tb_stochastic_alu_core;
  localparam int W = 9;
  localparam int L = 10;
  localparam logic [30:0] SA = 31'd134995;
  localparam logic [30:0] SB = 31'd7654321;

  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic in_ready, out_valid, busy, sn_bit;
  logic [W:0] result;
  int checks = 0, failures = 0;

  stochastic_alu_core #(.WIDTH(W), .LOG_LEN(L), .SEED_A(SA), .SEED_B(SB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .sn_bit(sn_bit));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference stream model: one iteration per generation cycle.
  function automatic int model(input logic [1:0] m, input int a, input int b);
    logic [30:0] la, lb;
    int ones;
    logic xa, xb, xd, s;
    la = SA; lb = SB; ones = 0; xd = 1'b0;
    for (int i = 0; i < (1 << L); i++) begin
      xa = int'(la[W-1:0]) < a;
      xb = int'(lb[W-1:0]) < b;
      case (m)
        2'b00:   s = ~(xa ^ xb);
        2'b01:   s = xa & xb;
        2'b10:   s = lb[30] ? xb : xa;
        default: s = xa & xd;
      endcase
      ones += int'(s);
      xd = xa;
      la = {la[29:0], la[30] ^ la[27]};
      lb = {lb[29:0], lb[30] ^ lb[27]};
    end
    return ones >> (L - W);
  endfunction

  // Accept, wait for out_valid (latency checked), return result and sn_bit hash.
  task automatic run_op(input string tag, input logic [1:0] m, input int a, input int b,
                        input bit pulse, output int res, output int hash);
    int cyc;
    mode = m; op_a = W'(a); op_b = W'(b); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0; hash = 0;
    while (!out_valid && cyc < 3000) begin
      tick();
      cyc++;
      hash = hash * 31 + int'(sn_bit);
      if (pulse && cyc == 200) begin
        in_valid = 1'b1; mode = 2'b00; op_a = '0; op_b = '0;
      end else in_valid = 1'b0;
    end
    chk({tag, "_lat"}, cyc, 1026);
    res = int'(result);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_ov_after"}, out_valid, 0);
  endtask

  initial begin
    int r, h, r2, h2, exp, held;
    rst_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_sn_bit", sn_bit, 0);

    run_op("zero_and", 2'b01, 0, 511, 1'b0, r, h);
    chk("zero_and_res", r, 0);
    chk("zero_and_in_ready_done", in_ready, 0);
    chk("zero_and_busy_done", busy, 1);
    handshake("zero_and");

    run_op("xnor_a", 2'b00, 0, 0, 1'b0, r, h);
    chk("xnor_a_res", r, 512);
    handshake("xnor_a");
    run_op("xnor_b", 2'b00, 0, 0, 1'b0, r, h);
    chk("xnor_b_res", r, 512);
    handshake("xnor_b");

    run_op("and_half", 2'b01, 256, 256, 1'b0, r, h);
    chk("and_half_range", (r >= 116 && r <= 140), 1);
    chk("and_half_model", r, model(2'b01, 256, 256));
    handshake("and_half");
    run_op("mux_half", 2'b10, 256, 256, 1'b0, r, h);
    chk("mux_half_range", (r >= 240 && r <= 272), 1);
    chk("mux_half_model", r, model(2'b10, 256, 256));
    handshake("mux_half");
    run_op("sq_half", 2'b11, 256, 0, 1'b0, r, h);
    chk("sq_half_range", (r >= 116 && r <= 140), 1);
    chk("sq_half_model", r, model(2'b11, 256, 0));
    handshake("sq_half");

    // in_valid pulses during RUN and DONE, out_ready held low in DONE
    exp = model(2'b01, 100, 300);
    run_op("hold", 2'b01, 100, 300, 1'b1, r, h);
    chk("hold_res0", r, exp);
    in_valid = 1'b1; mode = 2'b00; op_a = '0; op_b = '0;
    tick();
    in_valid = 1'b0;
    held = 1;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (!out_valid || int'(result) != exp || in_ready) held = 0;
    end
    chk("hold_stable", held, 1);
    chk("hold_out_valid", out_valid, 1);
    chk("hold_result", result, exp);
    chk("hold_in_ready", in_ready, 0);
    handshake("hold");

    // Reset mid-run
    mode = 2'b00; op_a = '0; op_b = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (300) tick();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_out_valid", out_valid, 0);

    exp = model(2'b10, 300, 50);
    run_op("post_rst", 2'b10, 300, 50, 1'b0, r, h);
    chk("post_rst_res", r, exp);
    handshake("post_rst");
    run_op("rerun", 2'b10, 300, 50, 1'b0, r2, h2);
    chk("rerun_res", r2, r);
    chk("rerun_trace", h2, h);
    handshake("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
